// File: rtl/multicycle_subtractor.sv
// Chunk-serial subtractor: computes A - B - Bin one CHUNK-bit slice per cycle,
// with a valid/ready handshake on both sides and a three-state control FSM.
module multicycle_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Difference,
    output logic             Borrow,
    output logic             Overflow
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK:0]   sub;
    int               idx;

    // Bit CHUNK of the widened result is the slice borrow-out.
    function automatic logic [CHUNK:0] chunk_sub(input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b,
                                                 input logic             bin);
        return {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
    endfunction

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        brw_d    = brw_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        idx      = int'(cnt_q) * CHUNK;
        sub      = chunk_sub(a_q[idx +: CHUNK], b_q[idx +: CHUNK], brw_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    brw_d   = Bin;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                diff_d[idx +: CHUNK] = sub[CHUNK-1:0];
                brw_d = sub[CHUNK];
                if (cnt_q == LAST) begin
                    // The last slice's MSB is the final Difference MSB.
                    borrow_d = sub[CHUNK];
                    ovf_d    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sub[CHUNK-1] ^ a_q[WIDTH-1]);
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            brw_q       <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            brw_q       <= brw_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operand holding registers are only meaningful in BUSY, so they need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign Difference = diff_q;
    assign Borrow     = borrow_q;
    assign Overflow   = ovf_q;

endmodule

// File: tb/tb_multicycle_subtractor.sv
// Bench for multicycle_subtractor: directed corner cases on the 16/4 instance and
// randomized traffic on four (WIDTH,CHUNK) configurations against an arithmetic model.
module tb_multicycle_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] a_i[4];
    logic [31:0] b_i[4];
    logic        bin_i[4];
    logic        iv[4];
    logic        ordy[4];

    logic        irdy[4];
    logic        ovld[4];
    logic [31:0] dif[4];
    logic        bo[4];
    logic        ov[4];

    logic [15:0] d0, d1, d2;
    logic [31:0] d3;

    int n_tests = 0;
    int n_fail  = 0;

    int wid[4] = '{16, 16, 16, 32};
    int nch[4] = '{4, 16, 1, 4};

    multicycle_subtractor #(.WIDTH(16), .CHUNK(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .A(a_i[0][15:0]), .B(b_i[0][15:0]), .Bin(bin_i[0]),
        .out_valid(ovld[0]), .out_ready(ordy[0]),
        .Difference(d0), .Borrow(bo[0]), .Overflow(ov[0]));

    multicycle_subtractor #(.WIDTH(16), .CHUNK(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .A(a_i[1][15:0]), .B(b_i[1][15:0]), .Bin(bin_i[1]),
        .out_valid(ovld[1]), .out_ready(ordy[1]),
        .Difference(d1), .Borrow(bo[1]), .Overflow(ov[1]));

    multicycle_subtractor #(.WIDTH(16), .CHUNK(16)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .A(a_i[2][15:0]), .B(b_i[2][15:0]), .Bin(bin_i[2]),
        .out_valid(ovld[2]), .out_ready(ordy[2]),
        .Difference(d2), .Borrow(bo[2]), .Overflow(ov[2]));

    multicycle_subtractor #(.WIDTH(32), .CHUNK(8)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(irdy[3]),
        .A(a_i[3]), .B(b_i[3]), .Bin(bin_i[3]),
        .out_valid(ovld[3]), .out_ready(ordy[3]),
        .Difference(d3), .Borrow(bo[3]), .Overflow(ov[3]));

    always_comb begin
        dif[0] = {16'h0, d0};
        dif[1] = {16'h0, d1};
        dif[2] = {16'h0, d2};
        dif[3] = d3;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return m[31:0];
    endfunction

    // Plain integer arithmetic of A - B - Bin with the defined flag rules.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic bin,
                         output logic [31:0] d, output logic brw, output logic ovf);
        longint ua, ub, r;
        logic [63:0] rr;
        ua  = longint'(a);
        ub  = longint'(b);
        r   = ua - ub - longint'(bin);
        rr  = r;
        d   = rr[31:0] & wmask(w);
        brw = (ua < ub + longint'(bin));
        ovf = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
    endtask

    task automatic scramble(input int inst);
        a_i[inst]   = $urandom & wmask(wid[inst]);
        b_i[inst]   = $urandom & wmask(wid[inst]);
        bin_i[inst] = 1'($urandom_range(0, 1));
        iv[inst]    = 1'($urandom_range(0, 1));
    endtask

    // One full transaction on one instance; assumes it is called just after a sampling point.
    task automatic run_op(input int inst, input logic [31:0] a, input logic [31:0] b, input logic bin,
                          input int hold, input bit rel_rst,
                          output logic [31:0] got_d, output logic got_b, output logic got_o);
        logic [31:0] ed;
        logic eb, eo;
        int waitc, lat;
        model(wid[inst], a, b, bin, ed, eb, eo);
        waitc = 0;
        while (!irdy[inst] && waitc < 50) begin
            @(posedge clk); #1; waitc++;
        end
        if (!irdy[inst]) chk("rdy_timeout", 0, 1);
        @(negedge clk);
        if (rel_rst) rst = 1'b0;
        a_i[inst] = a; b_i[inst] = b; bin_i[inst] = bin;
        iv[inst] = 1'b1; ordy[inst] = 1'b0;
        @(posedge clk); #1;
        chk("accept_rdy", irdy[inst], 0);
        lat = 0;
        while (!ovld[inst] && lat < 100) begin
            @(negedge clk); scramble(inst);
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, nch[inst]);
        chk("diff", dif[inst], ed);
        chk("borrow", bo[inst], eb);
        chk("ovf", ov[inst], eo);
        chk("busy_rdy", irdy[inst], 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); scramble(inst); ordy[inst] = 1'b0;
            @(posedge clk); #1;
            chk("hold_vld", ovld[inst], 1);
            chk("hold_rdy", irdy[inst], 0);
            chk("hold_diff", dif[inst], ed);
            chk("hold_brw", {bo[inst], ov[inst]}, {eb, eo});
        end
        // in_valid high on the handoff edge must not start a new operation.
        @(negedge clk); scramble(inst); iv[inst] = 1'b1; ordy[inst] = 1'b1;
        @(posedge clk); #1;
        chk("ho_vld", ovld[inst], 0);
        chk("ho_rdy", irdy[inst], 1);
        chk("idle_diff", dif[inst], ed);
        iv[inst] = 1'b0; ordy[inst] = 1'b0;
        got_d = dif[inst]; got_b = bo[inst]; got_o = ov[inst];
    endtask

    initial begin
        logic [31:0] gd;
        logic gb, go;
        logic [31:0] ra, rb, m;
        for (int i = 0; i < 4; i++) begin
            a_i[i] = '0; b_i[i] = '0; bin_i[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_rdy", irdy[i], 1);
            chk("rst_vld", ovld[i], 0);
            chk("rst_out", {dif[i], bo[i], ov[i]}, 34'h0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op(0, 32'h1234, 32'h0234, 1'b0, 0, 1'b0, gd, gb, go);
        chk("d_1234", {gd, gb, go}, {32'h1000, 1'b0, 1'b0});
        run_op(0, 32'h0000, 32'h0001, 1'b0, 0, 1'b0, gd, gb, go);
        chk("d_0m1", {gd, gb, go}, {32'hFFFF, 1'b1, 1'b0});
        run_op(0, 32'h0005, 32'h0005, 1'b1, 0, 1'b0, gd, gb, go);
        chk("d_bin", {gd, gb}, {32'hFFFF, 1'b1});
        run_op(0, 32'h8000, 32'h0001, 1'b0, 0, 1'b0, gd, gb, go);
        chk("d_ovf1", {gd, gb, go}, {32'h7FFF, 1'b0, 1'b1});
        run_op(0, 32'h7FFF, 32'hFFFF, 1'b0, 10, 1'b0, gd, gb, go);
        chk("d_ovf2", {gd, gb, go}, {32'h8000, 1'b1, 1'b1});

        // Reset during the second BUSY cycle discards the operation.
        @(negedge clk); a_i[0] = 32'h1235; b_i[0] = 32'h0001; bin_i[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); iv[0] = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_rdy", irdy[0], 1);
        chk("mid_rst_out", {ovld[0], dif[0], bo[0], ov[0]}, 35'h0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < nch[0] + 3; i++) begin
            @(posedge clk); #1;
            chk("no_pulse", ovld[0], 0);
        end
        // Reset wins over in_valid; accept happens on the first edge after release.
        @(negedge clk); rst = 1'b1; iv[0] = 1'b1; a_i[0] = 32'h0010; b_i[0] = 32'h0001;
        @(posedge clk); #1;
        chk("rst_prio", irdy[0], 1);
        run_op(0, 32'h0010, 32'h0001, 1'b0, 0, 1'b1, gd, gb, go);
        chk("d_post_rst", gd, 32'h000F);

        for (int inst = 0; inst < 4; inst++) begin
            m = wmask(wid[inst]);
            for (int n = 0; n < 1000; n++) begin
                case ($urandom_range(0, 7))
                    0: begin ra = 32'h0; rb = $urandom & m; end
                    1: begin ra = m; rb = m; end
                    2: begin ra = 32'h1 << (wid[inst] - 1); rb = $urandom & m; end
                    3: begin ra = $urandom & m; rb = ra; end
                    default: begin ra = $urandom & m; rb = $urandom & m; end
                endcase
                run_op(inst, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, gd, gb, go);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
